ws2812_frame_scheduler: RTL and testbench

WS2812_FRAME_SCHEDULER -- requirements
Module: ws2812_frame_scheduler

---
 rtl/ws2812_frame_scheduler_if.sv | 26 ++
 rtl/ws2812_frame_scheduler.sv | 87 ++++++++
 tb/tb_ws2812_frame_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_scheduler_if.sv
// ws2812_frame_scheduler_if: start/config, pixel-memory and RGB-controller signals of the frame scheduler
interface ws2812_frame_scheduler_if #(parameter int ADDR_W = 10);
   logic              start;
   logic [ADDR_W:0]   num_leds;
   logic [ADDR_W-1:0] base_addr;
   logic [7:0]        brightness;
   logic              pix_rd;
   logic [ADDR_W-1:0] pix_addr;
   logic [23:0]       pix_data;
   logic [7:0]        r;
   logic [7:0]        g;
   logic [7:0]        b;
   logic [1:0]        command;
   logic              cmd_request;
   logic              data_request;
   logic              busy;
   logic              frame_done;
   modport master (
      output start, num_leds, base_addr, brightness, pix_data, cmd_request, data_request,
      input  pix_rd, pix_addr, r, g, b, command, busy, frame_done
   );
   modport slave (
      input  start, num_leds, base_addr, brightness, pix_data, cmd_request, data_request,
      output pix_rd, pix_addr, r, g, b, command, busy, frame_done
   );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler: per start, reads num_leds pixels, scales them and hands them to the RGB controller
module ws2812_frame_scheduler #(parameter int ADDR_W = 10) (
   input logic                     clk,
   input logic                     rst,
   ws2812_frame_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, READY, RESET} state_t;
   state_t            state;
   logic [ADDR_W:0]   n;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   idx_n;
   logic [ADDR_W-1:0] base;
   logic [7:0]        bright;
   logic              consume;
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, k} + 16'd1);
      return p[15:8];
   endfunction
   assign idx_n   = idx + (ADDR_W+1)'(1);
   assign consume = (bus.cmd_request | bus.data_request) && bus.command == 2'b01;
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         n              <= '0;
         idx            <= '0;
         base           <= '0;
         bright         <= '0;
         bus.pix_rd     <= 1'b0;
         bus.pix_addr   <= '0;
         bus.r          <= '0;
         bus.g          <= '0;
         bus.b          <= '0;
         bus.command    <= 2'b00;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.pix_rd     <= 1'b0;
         bus.frame_done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               // a request above 2^ADDR_W has its top bit set; clamp to exactly 2^ADDR_W
               n        <= bus.num_leds[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : bus.num_leds;
               base     <= bus.base_addr;
               bright   <= bus.brightness;
               idx      <= '0;
               bus.busy <= 1'b1;
               if (bus.num_leds == '0) begin
                  state       <= RESET;
                  bus.command <= 2'b10;
               end else begin
                  state        <= FETCH;
                  bus.pix_rd   <= 1'b1;
                  bus.pix_addr <= bus.base_addr;
               end
            end
            FETCH: state <= CAPTURE;
            CAPTURE: begin
               bus.r       <= scale(bus.pix_data[23:16], bright);
               bus.g       <= scale(bus.pix_data[15:8], bright);
               bus.b       <= scale(bus.pix_data[7:0], bright);
               bus.command <= 2'b01;
               state       <= READY;
            end
            READY: if (consume) begin
               idx <= idx_n;
               if (idx_n == n) begin
                  state       <= RESET;
                  bus.command <= 2'b10;
               end else begin
                  state        <= FETCH;
                  bus.command  <= 2'b00;
                  bus.pix_rd   <= 1'b1;
                  bus.pix_addr <= base + idx_n[ADDR_W-1:0];
               end
            end
            RESET: if (bus.cmd_request) begin
               state          <= IDLE;
               bus.command    <= 2'b00;
               bus.frame_done <= 1'b1;
               bus.busy       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// tb_ws2812_frame_scheduler: directed frames against a pixel memory and a behavioural RGB controller
module tb_ws2812_frame_scheduler;
   logic clk;
   logic rst;
   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int fd_cnt = 0;
   int rd0;
   int fd0;
   int cnt;
   int cyc;
   logic [23:0] mem [0:1023];
   logic [9:0]  addr_q [$];
   logic [23:0] got_q [$];
   ws2812_frame_scheduler_if #(.ADDR_W(10)) bus ();
   ws2812_frame_scheduler #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) begin
      if (bus.pix_rd === 1'b1) begin
         bus.pix_data <= mem[bus.pix_addr];
         addr_q.push_back(bus.pix_addr);
         rd_cnt++;
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic start_frame(input logic [10:0] nl, input logic [9:0] ba, input logic [7:0] br);
      bus.start = 1'b1;
      bus.num_leds = nl;
      bus.base_addr = ba;
      bus.brightness = br;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic serve();
      int c = 0;
      while (bus.command !== 2'b10 && c < 200) begin
         if (bus.command === 2'b01) begin
            got_q.push_back({bus.r, bus.g, bus.b});
            bus.data_request = 1'b1;
            @(negedge clk);
            bus.data_request = 1'b0;
         end else @(negedge clk);
         c++;
      end
   endtask
   task automatic end_frame(input string tag);
      int f;
      chk({tag, "_cmd_reset"}, 32'(bus.command), 32'd2);
      chk({tag, "_busy_in_reset"}, 32'(bus.busy), 32'd1);
      f = fd_cnt;
      bus.cmd_request = 1'b1;
      @(negedge clk);
      bus.cmd_request = 1'b0;
      chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd1);
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      chk({tag, "_cmd_idle"}, 32'(bus.command), 32'd0);
      @(negedge clk);
      chk({tag, "_fd_pulse"}, 32'(bus.frame_done), 32'd0);
      chk({tag, "_fd_count"}, 32'(fd_cnt - f), 32'd1);
   endtask
   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      bus.num_leds = '0;
      bus.base_addr = '0;
      bus.brightness = '0;
      bus.cmd_request = 1'b0;
      bus.data_request = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
      mem[5] = 24'h112233;
      mem[6] = 24'h445566;
      mem[7] = 24'h778899;
      mem[10'h10] = 24'hFF8040;
      mem[10'h3FE] = 24'hA1B2C3;
      mem[10'h3FF] = 24'hD4E5F6;
      mem[10'h000] = 24'h0718F9;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
      chk("rst_cmd", 32'(bus.command), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_fd", 32'(bus.frame_done), 32'd0);
      chk("rst_addr", 32'(bus.pix_addr), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      bus.cmd_request = 1'b1;
      bus.data_request = 1'b1;
      @(negedge clk);
      bus.cmd_request = 1'b0;
      bus.data_request = 1'b0;
      @(negedge clk);
      chk("idle_req_cmd", 32'(bus.command), 32'd0);
      chk("idle_req_busy", 32'(bus.busy), 32'd0);
      chk("idle_req_fd", 32'(fd_cnt), 32'd0);
      // three-pixel frame at full brightness
      addr_q.delete();
      got_q.delete();
      start_frame(11'd3, 10'd5, 8'd255);
      chk("f1_busy", 32'(bus.busy), 32'd1);
      serve();
      chk("f1_rd_n", 32'(addr_q.size()), 32'd3);
      chk("f1_addr0", 32'(addr_q[0]), 32'd5);
      chk("f1_addr1", 32'(addr_q[1]), 32'd6);
      chk("f1_addr2", 32'(addr_q[2]), 32'd7);
      chk("f1_got_n", 32'(got_q.size()), 32'd3);
      chk("f1_got0", 32'(got_q[0]), 32'h112233);
      chk("f1_got1", 32'(got_q[1]), 32'h445566);
      chk("f1_got2", 32'(got_q[2]), 32'h778899);
      bus.data_request = 1'b1;
      @(negedge clk);
      bus.data_request = 1'b0;
      @(negedge clk);
      chk("f1_dreq_ignored", 32'(bus.command), 32'd2);
      end_frame("f1");
      // brightness scaling
      got_q.delete();
      start_frame(11'd1, 10'h10, 8'd127);
      serve();
      chk("f2_got_n", 32'(got_q.size()), 32'd1);
      chk("f2_scaled", 32'(got_q[0]), 32'h7F4020);
      end_frame("f2");
      // address wrap across the top of pixel memory
      addr_q.delete();
      got_q.delete();
      start_frame(11'd3, 10'h3FE, 8'd255);
      serve();
      chk("f3_rd_n", 32'(addr_q.size()), 32'd3);
      chk("f3_addr0", 32'(addr_q[0]), 32'h3FE);
      chk("f3_addr1", 32'(addr_q[1]), 32'h3FF);
      chk("f3_addr2", 32'(addr_q[2]), 32'h000);
      chk("f3_got2", 32'(got_q[2]), 32'h0718F9);
      end_frame("f3");
      // empty frame goes straight to reset
      rd0 = rd_cnt;
      start_frame(11'd0, 10'd5, 8'd255);
      chk("f4_cmd", 32'(bus.command), 32'd2);
      @(negedge clk);
      chk("f4_no_rd", 32'(rd_cnt - rd0), 32'd0);
      end_frame("f4");
      // abort after the second consume, with start held and config changed mid-frame
      rd0 = rd_cnt;
      fd0 = fd_cnt;
      start_frame(11'd4, 10'h20, 8'd255);
      cnt = 0;
      cyc = 0;
      while (cnt < 2 && cyc < 100) begin
         bus.start = 1'b1;
         bus.num_leds = 11'd1;
         if (bus.command === 2'b01) begin
            bus.data_request = 1'b1;
            cnt++;
         end else bus.data_request = 1'b0;
         @(negedge clk);
         cyc++;
      end
      bus.data_request = 1'b0;
      chk("f5_consumes", 32'(cnt), 32'd2);
      chk("f5_mid_cmd", 32'(bus.command), 32'd0);
      chk("f5_mid_rd", 32'(bus.pix_rd), 32'd1);
      rst = 1'b1;
      bus.cmd_request = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      bus.cmd_request = 1'b0;
      chk("f5_abort_cmd", 32'(bus.command), 32'd0);
      chk("f5_abort_busy", 32'(bus.busy), 32'd0);
      chk("f5_abort_fd", 32'(bus.frame_done), 32'd0);
      chk("f5_abort_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
      repeat (5) @(negedge clk);
      chk("f5_no_fd", 32'(fd_cnt - fd0), 32'd0);
      chk("f5_rd_cnt", 32'(rd_cnt - rd0), 32'd3);
      chk("f5_idle_busy", 32'(bus.busy), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
